// File: rtl/chien_ctrl_if.sv
// Handshake and datapath bundle for the Chien search sequencer.
// Carries the optional abort input when CHIEN_CTRL_ABORT_EN is defined.
interface chien_ctrl_if #(
    parameter int unsigned M = 4,
    parameter int unsigned T = 3,
    parameter int unsigned K = 5
);
    localparam int unsigned SigmaW = M * (T + 1);
    localparam int unsigned DegW   = $clog2(T + 1) + 1;
    localparam int unsigned IdxW   = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CntW   = $clog2(K + 1);

    logic              sigma_valid;
    logic              sigma_ready;
    logic [SigmaW-1:0] sigma_in;
    logic [DegW-1:0]   sigma_deg;
    logic              chien_start;
    logic              chien_ce;
    logic [SigmaW-1:0] chien_sigma;
    logic              chien_err;
    logic              bit_valid;
    logic              bit_ready;
    logic              bit_err;
    logic [IdxW-1:0]   bit_idx;
    logic              bit_last;
    logic              stat_valid;
    logic [CntW-1:0]   err_count;
    logic              fail;
`ifdef CHIEN_CTRL_ABORT_EN
    logic              abort;

    modport slave (
        input  sigma_valid, sigma_in, sigma_deg, chien_err, bit_ready, abort,
        output sigma_ready, chien_start, chien_ce, chien_sigma, bit_valid, bit_err,
               bit_idx, bit_last, stat_valid, err_count, fail
    );

    modport master (
        output sigma_valid, sigma_in, sigma_deg, chien_err, bit_ready, abort,
        input  sigma_ready, chien_start, chien_ce, chien_sigma, bit_valid, bit_err,
               bit_idx, bit_last, stat_valid, err_count, fail
    );
`else
    modport slave (
        input  sigma_valid, sigma_in, sigma_deg, chien_err, bit_ready,
        output sigma_ready, chien_start, chien_ce, chien_sigma, bit_valid, bit_err,
               bit_idx, bit_last, stat_valid, err_count, fail
    );

    modport master (
        output sigma_valid, sigma_in, sigma_deg, chien_err, bit_ready,
        input  sigma_ready, chien_start, chien_ce, chien_sigma, bit_valid, bit_err,
               bit_idx, bit_last, stat_valid, err_count, fail
    );
`endif
endinterface

// File: rtl/chien_ctrl.sv
// Chien search sequencer: accepts sigma, steps the datapath over K positions, reports count/fail.
// Optional abort input enabled by defining CHIEN_CTRL_ABORT_EN.
module chien_ctrl #(
    parameter int unsigned M = 4,
    parameter int unsigned T = 3,
    parameter int unsigned K = 5
) (
    input logic         clk,
    input logic         rst_n,
    chien_ctrl_if.slave bus
);
    localparam int unsigned DegW = $clog2(T + 1) + 1;
    localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CntW = $clog2(K + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DegW-1:0] deg_q, deg_d;
    logic            fail_q, fail_d;
    logic            abort_req;

    logic            sigma_ready;
    logic            chien_start;
    logic            chien_ce;
    logic            bit_valid;
    logic            bit_err;
    logic            bit_last;
    logic            stat_valid;

`ifdef CHIEN_CTRL_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            deg_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            deg_q   <= deg_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        deg_d       = deg_q;
        fail_d      = fail_q;
        sigma_ready = 1'b0;
        chien_start = 1'b0;
        chien_ce    = 1'b0;
        bit_valid   = 1'b0;
        bit_err     = 1'b0;
        bit_last    = 1'b0;
        stat_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                sigma_ready = 1'b1;
                chien_start = bus.sigma_valid;
                if (bus.sigma_valid) begin
                    deg_d   = bus.sigma_deg;
                    idx_d   = '0;
                    cnt_d   = '0;
                    fail_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                bit_valid = 1'b1;
                bit_err   = bus.chien_err;
                bit_last  = (idx_q == IdxW'(K - 1));
                // Abort wins over a simultaneous beat: the beat is dropped, datapath not stepped.
                if (abort_req) begin
                    cnt_d   = '0;
                    fail_d  = 1'b0;
                    state_d = StIdle;
                end else if (bus.bit_ready) begin
                    chien_ce = 1'b1;
                    if (bus.chien_err && (cnt_q < CntW'(K))) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    if (bit_last) begin
                        fail_d  = (32'(cnt_d) != 32'(deg_q));
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StDone: begin
                if (abort_req) begin
                    cnt_d  = '0;
                    fail_d = 1'b0;
                end else begin
                    stat_valid = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Strobes are suppressed while reset is asserted so the datapath never sees a stray edge.
        if (!rst_n) begin
            chien_start = 1'b0;
            chien_ce    = 1'b0;
            stat_valid  = 1'b0;
        end
    end

    assign bus.sigma_ready = sigma_ready;
    assign bus.chien_start = chien_start;
    assign bus.chien_ce    = chien_ce;
    assign bus.chien_sigma = bus.sigma_in;
    assign bus.bit_valid   = bit_valid;
    assign bus.bit_err     = bit_err;
    assign bus.bit_idx     = idx_q;
    assign bus.bit_last    = bit_last;
    assign bus.stat_valid  = stat_valid;
    assign bus.err_count   = cnt_q;
    assign bus.fail        = fail_q;
endmodule

// File: tb/tb_chien_ctrl.sv
// Directed bench for chien_ctrl with a GF(16) Chien datapath model driving chien_err.
module tb_chien_ctrl;
    localparam int M = 4;
    localparam int T = 3;
    localparam int K = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    chien_ctrl_if #(.M(M), .T(T), .K(K)) bus ();

    chien_ctrl #(.M(M), .T(T), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: register i holds sigma_i * alpha^(i*pos); root when the sum is zero.
    function automatic logic [3:0] mul_alpha(input logic [3:0] v);
        return {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic [3:0] mul_alpha_n(input logic [3:0] v, input int n);
        logic [3:0] r;
        r = v;
        for (int j = 0; j < n; j++) r = mul_alpha(r);
        return r;
    endfunction

    logic [M-1:0] dp_r [T+1];
    logic [M-1:0] dp_sum;

    always @(posedge clk) begin
        if (bus.chien_start) begin
            for (int i = 0; i <= T; i++) dp_r[i] <= bus.chien_sigma[i*M +: M];
        end else if (bus.chien_ce) begin
            for (int i = 0; i <= T; i++) dp_r[i] <= mul_alpha_n(dp_r[i], i);
        end
    end

    always_comb begin
        dp_sum = '0;
        for (int i = 0; i <= T; i++) dp_sum = dp_sum ^ dp_r[i];
    end

    assign bus.chien_err = (dp_sum == '0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input int idx, input logic exp_err, input logic rdy);
        bus.bit_ready = rdy;
        #1;
        chk("bit_valid", 32'(bus.bit_valid), 32'd1);
        chk("bit_idx", 32'(bus.bit_idx), idx);
        chk("bit_err", 32'(bus.bit_err), 32'(exp_err));
        chk("bit_last", 32'(bus.bit_last), 32'(idx == K - 1));
        chk("chien_ce", 32'(bus.chien_ce), 32'(rdy));
        chk("chien_start_run", 32'(bus.chien_start), 32'd0);
        chk("sigma_ready_run", 32'(bus.sigma_ready), 32'd0);
        chk("stat_valid_run", 32'(bus.stat_valid), 32'd0);
        @(negedge clk);
    endtask

    task automatic accept(input logic [15:0] sig, input logic [2:0] deg);
        bus.sigma_in    = sig;
        bus.sigma_deg   = deg;
        bus.sigma_valid = 1'b1;
        bus.bit_ready   = 1'b1;
        #1;
        chk("sigma_ready_idle", 32'(bus.sigma_ready), 32'd1);
        chk("chien_start", 32'(bus.chien_start), 32'd1);
        chk("chien_ce_idle", 32'(bus.chien_ce), 32'd0);
        chk("chien_sigma", 32'(bus.chien_sigma), 32'(sig));
        @(negedge clk);
        bus.sigma_valid = 1'b0;
    endtask

    task automatic run_cw(input logic [15:0] sig, input logic [2:0] deg, input logic [4:0] emask,
                          input int ecnt, input logic efail, input int stall_at,
                          input int stall_len);
        accept(sig, deg);
        for (int i = 0; i < K; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) beat(i, emask[i], 1'b0);
            end
            beat(i, emask[i], 1'b1);
        end
        #1;
        chk("stat_valid", 32'(bus.stat_valid), 32'd1);
        chk("err_count", 32'(bus.err_count), ecnt);
        chk("fail", 32'(bus.fail), 32'(efail));
        chk("bit_valid_done", 32'(bus.bit_valid), 32'd0);
        chk("sigma_ready_done", 32'(bus.sigma_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("stat_valid_once", 32'(bus.stat_valid), 32'd0);
        chk("sigma_ready_after", 32'(bus.sigma_ready), 32'd1);
        chk("err_count_hold", 32'(bus.err_count), ecnt);
        chk("fail_hold", 32'(bus.fail), 32'(efail));
        @(negedge clk);
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.sigma_valid = 1'b0;
        bus.sigma_in    = '0;
        bus.sigma_deg   = '0;
        bus.bit_ready   = 1'b1;
`ifdef CHIEN_CTRL_ABORT_EN
        bus.abort       = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_sigma_ready", 32'(bus.sigma_ready), 32'd1);
        chk("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
        chk("rst_stat_valid", 32'(bus.stat_valid), 32'd0);
        chk("rst_bit_idx", 32'(bus.bit_idx), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_fail", 32'(bus.fail), 32'd0);
        chk("rst_chien_start", 32'(bus.chien_start), 32'd0);
        chk("rst_chien_ce", 32'(bus.chien_ce), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // sigma = 1: no roots anywhere.
        run_cw(16'h0001, 3'd0, 5'b00000, 0, 1'b0, -1, 0);
        // sigma = 1 + alpha^13 x: single root at alpha^2.
        run_cw(16'h00D1, 3'd1, 5'b00100, 1, 1'b0, -1, 0);
        // Same with a 3-cycle stall at idx 1.
        run_cw(16'h00D1, 3'd1, 5'b00100, 1, 1'b0, 1, 3);
        // Degree mismatch.
        run_cw(16'h00D1, 3'd2, 5'b00100, 1, 1'b1, -1, 0);
        // All-zero sigma: every position flags, count reaches K.
        run_cw(16'h0000, 3'd0, 5'b11111, 5, 1'b1, -1, 0);

        // Reset mid-RUN at idx 3.
        accept(16'h00D1, 3'd1);
        beat(0, 1'b0, 1'b1);
        beat(1, 1'b0, 1'b1);
        beat(2, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstrun_chien_ce", 32'(bus.chien_ce), 32'd0);
        chk("rstrun_chien_start", 32'(bus.chien_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstrun_bit_valid", 32'(bus.bit_valid), 32'd0);
        chk("rstrun_sigma_ready", 32'(bus.sigma_ready), 32'd1);
        chk("rstrun_stat_valid", 32'(bus.stat_valid), 32'd0);
        chk("rstrun_bit_idx", 32'(bus.bit_idx), 32'd0);
        chk("rstrun_err_count", 32'(bus.err_count), 32'd0);
        @(negedge clk);
        #1;
        chk("rstrun_no_stat", 32'(bus.stat_valid), 32'd0);
        @(negedge clk);
        run_cw(16'h00D1, 3'd1, 5'b00100, 1, 1'b0, -1, 0);

`ifdef CHIEN_CTRL_ABORT_EN
        accept(16'h00D1, 3'd1);
        beat(0, 1'b0, 1'b1);
        bus.bit_ready = 1'b1;
        bus.abort     = 1'b1;
        #1;
        chk("abort_chien_ce", 32'(bus.chien_ce), 32'd0);
        chk("abort_bit_valid", 32'(bus.bit_valid), 32'd1);
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        chk("abort_bit_valid_after", 32'(bus.bit_valid), 32'd0);
        chk("abort_sigma_ready", 32'(bus.sigma_ready), 32'd1);
        chk("abort_stat_valid", 32'(bus.stat_valid), 32'd0);
        chk("abort_err_count", 32'(bus.err_count), 32'd0);
        chk("abort_fail", 32'(bus.fail), 32'd0);
        @(negedge clk);
        #1;
        chk("abort_no_stat", 32'(bus.stat_valid), 32'd0);
        @(negedge clk);
        run_cw(16'h00D1, 3'd1, 5'b00100, 1, 1'b0, -1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
